// File: rtl/apb_compare_monitor_pkg.sv
// apb_mon_pkg: shared types and constants for the APB compare monitor.
//   mon_state_e : burst-tracking FSM states
//   CYC_W       : width of the free-running cycle counter / FIRST_CYCLE
package apb_mon_pkg;

  localparam int CYC_W = 32;

  typedef enum logic [1:0] {
    CLEAN     = 2'd0,  // no mismatch since reset/CLR
    BURST     = 2'd1,  // last sampled cycle mismatched
    RECOVERED = 2'd2   // errors seen, last sampled cycle clean
  } mon_state_e;

endpackage

// File: rtl/apb_compare_monitor_if.sv
// apb_compare_monitor_if: compare inputs and result outputs of the monitor.
//   master : drives CMP_EN/CLR/DUT_DATA/GOLD_DATA/MASK, observes results
//   slave  : the monitor itself
interface apb_compare_monitor_if
  import apb_mon_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int CNT_W = 8
);
  logic             CMP_EN;
  logic             CLR;
  logic [WIDTH-1:0] DUT_DATA;
  logic [WIDTH-1:0] GOLD_DATA;
  logic [WIDTH-1:0] MASK;
  logic             ERROR;
  logic [CNT_W-1:0] ERR_COUNT;
  logic             FIRST_VALID;
  logic [CYC_W-1:0] FIRST_CYCLE;
  logic [WIDTH-1:0] FIRST_VEC;
  logic [CNT_W-1:0] BURST_MAX;
  logic             FAIL;

  modport master (
    output CMP_EN, CLR, DUT_DATA, GOLD_DATA, MASK,
    input  ERROR, ERR_COUNT, FIRST_VALID, FIRST_CYCLE, FIRST_VEC, BURST_MAX, FAIL
  );

  modport slave (
    input  CMP_EN, CLR, DUT_DATA, GOLD_DATA, MASK,
    output ERROR, ERR_COUNT, FIRST_VALID, FIRST_CYCLE, FIRST_VEC, BURST_MAX, FAIL
  );
endinterface

// File: rtl/apb_compare_monitor_cmp.sv
// apb_mon_cmp: per-bit masked compare.
//   dut, gold, mask : WIDTH-bit operands, mask bit 1 = compared
//   mis_vec         : masked mismatch vector; an X/Z on a compared bit counts
//   any_mis         : OR of mis_vec
module apb_mon_cmp #(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH-1:0] dut,
  input  logic [WIDTH-1:0] gold,
  input  logic [WIDTH-1:0] mask,
  output logic [WIDTH-1:0] mis_vec,
  output logic             any_mis
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    // Case inequality so that an unknown difference on a compared bit is
    // reported as a mismatch rather than silently ignored.
    assign mis_vec[i] = (mask[i] !== 1'b0) && ((dut[i] ^ gold[i]) !== 1'b0);
  end

  assign any_mis = |mis_vec;
endmodule

// File: rtl/apb_compare_monitor.sv
// apb_compare_monitor: compares DUT outputs against a golden model each
// SYSCLK edge and keeps sticky result state (error flag, saturating error
// count, first-mismatch capture, longest mismatch burst, threshold FAIL).
//   SYSCLK  : sampling clock
//   PRESETn : asynchronous active-low reset
//   bus     : apb_compare_monitor_if.slave (compare inputs, result outputs)
// Optional build macro APB_MON_DISPLAY_EN: prints each mismatch and the FAIL
// assertion to the console; ports behave identically either way.
module apb_compare_monitor
  import apb_mon_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int CNT_W  = 8,
  parameter int THRESH = 1
) (
  input  logic                 SYSCLK,
  input  logic                 PRESETn,
  apb_compare_monitor_if.slave bus
);
  localparam logic [CNT_W-1:0] THR = CNT_W'(THRESH);

  logic [WIDTH-1:0] mis_vec;
  logic             any_mis;
  logic             hit;

  logic [CYC_W-1:0] cyc;
  mon_state_e       state, state_n;
  logic [CNT_W-1:0] burst_len, burst_len_n;
  logic [CNT_W-1:0] err_cnt, err_cnt_n;
  logic [CNT_W-1:0] burst_max, burst_max_n;
  logic             first_vld;
  logic [CYC_W-1:0] first_cyc;
  logic [WIDTH-1:0] first_vec;
  logic             fail_q;

  apb_mon_cmp #(.WIDTH(WIDTH)) u_cmp (
    .dut     (bus.DUT_DATA),
    .gold    (bus.GOLD_DATA),
    .mask    (bus.MASK),
    .mis_vec (mis_vec),
    .any_mis (any_mis)
  );

  assign hit = bus.CMP_EN & any_mis;

  // Free-running cycle counter; CLR deliberately leaves it alone so that
  // FIRST_CYCLE stays meaningful relative to reset.
  always_ff @(posedge SYSCLK or negedge PRESETn) begin
    if (!PRESETn) cyc <= '0;
    else          cyc <= cyc + CYC_W'(1);
  end

  // Burst FSM: state register
  always_ff @(posedge SYSCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= CLEAN;
      burst_len <= '0;
    end else begin
      state     <= state_n;
      burst_len <= burst_len_n;
    end
  end

  // Burst FSM: next state and running burst length. CLR wins over a
  // simultaneous mismatch.
  always_comb begin
    state_n     = state;
    burst_len_n = burst_len;
    if (bus.CLR) begin
      state_n     = CLEAN;
      burst_len_n = '0;
    end else if (hit) begin
      state_n = BURST;
      if (state == BURST)
        burst_len_n = (burst_len == '1) ? burst_len : burst_len + CNT_W'(1);
      else
        burst_len_n = CNT_W'(1);
    end else begin
      burst_len_n = '0;
      if (state == BURST) state_n = RECOVERED;
    end
  end

  // Values the result registers take if this edge records a mismatch.
  always_comb begin
    err_cnt_n   = (err_cnt == '1) ? err_cnt : err_cnt + CNT_W'(1);
    burst_max_n = (burst_len_n > burst_max) ? burst_len_n : burst_max;
  end

  always_ff @(posedge SYSCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      err_cnt   <= '0;
      burst_max <= '0;
      first_vld <= 1'b0;
      first_cyc <= '0;
      first_vec <= '0;
      fail_q    <= 1'b0;
    end else if (bus.CLR) begin
      err_cnt   <= '0;
      burst_max <= '0;
      first_vld <= 1'b0;
      first_cyc <= '0;
      first_vec <= '0;
      fail_q    <= 1'b0;
    end else if (hit) begin
      err_cnt   <= err_cnt_n;
      burst_max <= burst_max_n;
      fail_q    <= fail_q | (err_cnt_n >= THR);
      if (!first_vld) begin
        first_vld <= 1'b1;
        first_cyc <= cyc;
        first_vec <= mis_vec;
      end
    end
  end

  // ERROR and FIRST_VALID are both "a mismatch has been captured".
  assign bus.ERROR       = first_vld;
  assign bus.FIRST_VALID = first_vld;
  assign bus.ERR_COUNT   = err_cnt;
  assign bus.FIRST_CYCLE = first_cyc;
  assign bus.FIRST_VEC   = first_vec;
  assign bus.BURST_MAX   = burst_max;
  assign bus.FAIL        = fail_q;

`ifdef APB_MON_DISPLAY_EN
  always @(posedge SYSCLK) begin
    if (PRESETn && !bus.CLR && hit) begin
      $display("%0t apb_compare_monitor: mismatch cycle=%0d err_count=%0d mis_vec=%h",
               $time, cyc, err_cnt_n, mis_vec);
      if (!fail_q && (err_cnt_n >= THR)) $display("FAIL");
    end
  end
`else
  // Silent build: no console output.
`endif

endmodule

// File: tb/tb_apb_compare_monitor.sv
// tb_apb_compare_monitor: randomized + directed bench for apb_compare_monitor.
// Two monitors share the stimulus: d0 (CNT_W=4, THRESH=1) and
// d1 (CNT_W=8, THRESH=5). The reference model keeps the full history of
// per-cycle mismatch outcomes since the last reset/CLR and derives every
// expected output from that history.
module tb_apb_compare_monitor;
  import apb_mon_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  apb_compare_monitor_if #(.WIDTH(10), .CNT_W(4)) i0 ();
  apb_compare_monitor_if #(.WIDTH(10), .CNT_W(8)) i1 ();

  apb_compare_monitor #(.WIDTH(10), .CNT_W(4), .THRESH(1)) d0 (
    .SYSCLK(clk), .PRESETn(rst_n), .bus(i0));
  apb_compare_monitor #(.WIDTH(10), .CNT_W(8), .THRESH(5)) d1 (
    .SYSCLK(clk), .PRESETn(rst_n), .bus(i1));

  // ---------------- reference model ----------------
  bit          hist[$];   // 1 = mismatching sampled cycle since reset/CLR
  int unsigned m_cyc;
  bit          m_fv;
  int unsigned m_fcyc;
  logic [9:0]  m_fvec;

  function automatic void model_reset();
    hist.delete();
    m_cyc = 0; m_fv = 0; m_fcyc = 0; m_fvec = '0;
  endfunction

  function automatic void model_step(bit en, bit clr, logic [9:0] d, logic [9:0] g,
                                     logic [9:0] mask);
    logic [9:0] mv;
    bit h;
    for (int i = 0; i < 10; i++) mv[i] = (mask[i] !== 1'b0) && ((d[i] ^ g[i]) !== 1'b0);
    h = en && (mv != 0);
    if (clr) begin
      hist.delete(); m_fv = 0; m_fcyc = 0; m_fvec = '0;
    end else begin
      hist.push_back(h);
      if (h && !m_fv) begin m_fv = 1; m_fcyc = m_cyc; m_fvec = mv; end
    end
    m_cyc++;
  endfunction

  // {ERROR, ERR_COUNT(8), FIRST_VALID, FIRST_CYCLE(32), FIRST_VEC(10), BURST_MAX(8), FAIL, state(2)}
  function automatic logic [62:0] exp_vec(int k);
    int cmax = (k != 0) ? 255 : 15;
    int thr  = (k != 0) ? 5 : 1;
    int n = 0, run = 0, bmax = 0, cnt;
    mon_state_e st;
    foreach (hist[i]) begin
      if (hist[i]) begin
        n++; run++;
        if (((run > cmax) ? cmax : run) > bmax) bmax = (run > cmax) ? cmax : run;
      end else run = 0;
    end
    cnt = (n > cmax) ? cmax : n;
    if (n == 0) st = CLEAN;
    else st = hist[hist.size()-1] ? BURST : RECOVERED;
    return {n > 0, 8'(cnt), m_fv, m_fcyc, m_fvec, 8'(bmax), n >= thr, 2'(st)};
  endfunction

  function automatic logic [62:0] obs_vec(int k);
    if (k == 0)
      return {i0.ERROR, 4'b0, i0.ERR_COUNT, i0.FIRST_VALID, i0.FIRST_CYCLE, i0.FIRST_VEC,
              4'b0, i0.BURST_MAX, i0.FAIL, 2'(d0.state)};
    return {i1.ERROR, i1.ERR_COUNT, i1.FIRST_VALID, i1.FIRST_CYCLE, i1.FIRST_VEC,
            i1.BURST_MAX, i1.FAIL, 2'(d1.state)};
  endfunction

  // ---------------- stimulus ----------------
  task automatic drive(bit en, bit clr, logic [9:0] d, logic [9:0] g, logic [9:0] mask);
    i0.CMP_EN = en; i0.CLR = clr; i0.DUT_DATA = d; i0.GOLD_DATA = g; i0.MASK = mask;
    i1.CMP_EN = en; i1.CLR = clr; i1.DUT_DATA = d; i1.GOLD_DATA = g; i1.MASK = mask;
  endtask

  // One sampled cycle: drive, advance model, clock, settle.
  task automatic cycle(bit en, bit clr, logic [9:0] d, logic [9:0] g, logic [9:0] mask);
    drive(en, clr, d, g, mask);
    model_step(en, clr, d, g, mask);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, '0, '0, 10'h3FF);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (obs_vec(k) !== exp_vec(k)) begin
        n_fail++; $display("FAIL reset k=%0d got=%h exp=%h", k, obs_vec(k), exp_vec(k));
      end
    end
    n_chk++;
    if ({i0.ERROR, i0.ERR_COUNT, i0.FAIL, i1.FAIL} !== 7'd0 || d0.state !== CLEAN) begin
      n_fail++; $display("FAIL reset_const got=%b state=%0d exp=0", {i0.ERROR, i0.ERR_COUNT}, d0.state);
    end
  endtask

  task automatic test_clean();
    logic [9:0] g;
    for (int c = 0; c < 20; c++) begin
      g = 10'($urandom);
      cycle(1, 0, g, g, 10'h3FF);
      for (int k = 0; k < 2; k++) begin
        n_chk++;
        if (obs_vec(k) !== exp_vec(k)) begin
          n_fail++; $display("FAIL clean k=%0d got=%h exp=%h", k, obs_vec(k), exp_vec(k));
        end
      end
    end
    n_chk++;
    if (i1.ERROR !== 1'b0 || i1.ERR_COUNT !== 8'd0 || d1.state !== CLEAN) begin
      n_fail++; $display("FAIL clean_const err=%b cnt=%0d exp 0/0", i1.ERROR, i1.ERR_COUNT);
    end
  endtask

  task automatic test_first();
    logic [9:0] g;
    do_reset();
    for (int c = 0; c < 5; c++) begin g = 10'($urandom); cycle(1, 0, g, g, 10'h3FF); end
    g = 10'($urandom);
    cycle(1, 0, g ^ 10'h004, g, 10'h3FF);
    n_chk++;
    if (i0.FIRST_CYCLE !== 32'd5 || i0.FIRST_VEC !== 10'h004 || i0.ERR_COUNT !== 4'd1 ||
        i0.FAIL !== 1'b1 || i0.FIRST_VALID !== 1'b1 || i1.FAIL !== 1'b0) begin
      n_fail++;
      $display("FAIL first_capture got cyc=%0d vec=%h cnt=%0d fail0=%b fail1=%b exp 5/004/1/1/0",
               i0.FIRST_CYCLE, i0.FIRST_VEC, i0.ERR_COUNT, i0.FAIL, i1.FAIL);
    end
    // Later mismatches must leave the capture alone; d1 reaches THRESH=5.
    for (int c = 0; c < 4; c++) begin g = 10'($urandom); cycle(1, 0, g ^ 10'h300, g, 10'h3FF); end
    n_chk++;
    if (i1.FIRST_CYCLE !== 32'd5 || i1.FIRST_VEC !== 10'h004 || i1.FAIL !== 1'b1 ||
        i1.ERR_COUNT !== 8'd5) begin
      n_fail++;
      $display("FAIL first_hold got cyc=%0d vec=%h fail1=%b cnt=%0d exp 5/004/1/5",
               i1.FIRST_CYCLE, i1.FIRST_VEC, i1.FAIL, i1.ERR_COUNT);
    end
  endtask

  task automatic test_mask_en();
    logic [9:0] g;
    cycle(0, 1, '0, '0, 10'h3FF);
    for (int c = 0; c < 4; c++) begin g = 10'($urandom); cycle(1, 0, g ^ 10'h008, g, 10'h3F7); end
    n_chk++;
    if (i0.ERROR !== 1'b0 || i1.ERR_COUNT !== 8'd0) begin
      n_fail++; $display("FAIL mask_off err=%b cnt=%0d exp 0/0", i0.ERROR, i1.ERR_COUNT);
    end
    for (int c = 0; c < 4; c++) begin g = 10'($urandom); cycle(0, 0, g ^ 10'h008, g, 10'h3FF); end
    n_chk++;
    if (i0.ERROR !== 1'b0 || i1.ERR_COUNT !== 8'd0 || d0.state !== CLEAN) begin
      n_fail++; $display("FAIL cmp_en_off err=%b cnt=%0d exp 0/0", i0.ERROR, i1.ERR_COUNT);
    end
  endtask

  task automatic test_bursts();
    logic [9:0] g;
    cycle(0, 1, '0, '0, 10'h3FF);
    for (int c = 0; c < 3; c++) begin g = 10'($urandom); cycle(1, 0, ~g, g, 10'h3FF); end
    g = 10'($urandom); cycle(1, 0, g, g, 10'h3FF);
    for (int c = 0; c < 5; c++) begin g = 10'($urandom); cycle(1, 0, g ^ 10'h201, g, 10'h3FF); end
    g = 10'($urandom); cycle(1, 0, g, g, 10'h3FF);
    n_chk++;
    if (i1.BURST_MAX !== 8'd5 || i1.ERR_COUNT !== 8'd8 || d1.state !== RECOVERED ||
        i0.BURST_MAX !== 4'd5) begin
      n_fail++; $display("FAIL bursts got max=%0d cnt=%0d state=%0d exp 5/8/RECOVERED",
                         i1.BURST_MAX, i1.ERR_COUNT, d1.state);
    end
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (obs_vec(k) !== exp_vec(k)) begin
        n_fail++; $display("FAIL bursts_model k=%0d got=%h exp=%h", k, obs_vec(k), exp_vec(k));
      end
    end
  endtask

  task automatic test_saturate();
    logic [9:0] g;
    cycle(0, 1, '0, '0, 10'h3FF);
    for (int c = 0; c < 20; c++) begin g = 10'($urandom); cycle(1, 0, g ^ 10'h010, g, 10'h3FF); end
    n_chk++;
    if (i0.ERR_COUNT !== 4'd15 || i0.BURST_MAX !== 4'd15 || i1.ERR_COUNT !== 8'd20 ||
        i1.BURST_MAX !== 8'd20) begin
      n_fail++; $display("FAIL saturate got cnt0=%0d max0=%0d cnt1=%0d max1=%0d exp 15/15/20/20",
                         i0.ERR_COUNT, i0.BURST_MAX, i1.ERR_COUNT, i1.BURST_MAX);
    end
    g = 10'($urandom);
    cycle(1, 1, g ^ 10'h010, g, 10'h3FF);
    n_chk++;
    if ({i0.ERROR, i0.ERR_COUNT, i0.FIRST_VALID, i0.FIRST_CYCLE, i0.FIRST_VEC, i0.BURST_MAX,
         i0.FAIL} !== '0 || d0.state !== CLEAN || i1.ERR_COUNT !== 8'd0) begin
      n_fail++; $display("FAIL clr_priority got cnt=%0d err=%b state=%0d exp all 0",
                         i0.ERR_COUNT, i0.ERROR, d0.state);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [9:0] g;
    for (int c = 0; c < 3; c++) begin g = 10'($urandom); cycle(1, 0, g ^ 10'h002, g, 10'h3FF); end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({i1.ERROR, i1.ERR_COUNT, i1.FIRST_VALID, i1.FIRST_CYCLE, i1.FIRST_VEC, i1.BURST_MAX,
         i1.FAIL} !== '0 || d1.state !== CLEAN) begin
      n_fail++; $display("FAIL async_reset got cnt=%0d err=%b exp all 0", i1.ERR_COUNT, i1.ERROR);
    end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    g = 10'($urandom);
    cycle(1, 0, g ^ 10'h080, g, 10'h3FF);
    n_chk++;
    if (i0.FIRST_CYCLE !== 32'd0 || i0.ERR_COUNT !== 4'd1 || i1.BURST_MAX !== 8'd1 ||
        i0.FIRST_VEC !== 10'h080) begin
      n_fail++; $display("FAIL post_reset got cyc=%0d cnt=%0d max=%0d exp 0/1/1",
                         i0.FIRST_CYCLE, i0.ERR_COUNT, i1.BURST_MAX);
    end
  endtask

  task automatic test_random();
    logic [9:0] g, d, m;
    bit bad = 0, en, clr;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 4) == 0) bad = !bad;   // produce runs of mismatches
      en  = ($urandom_range(0, 5) != 0);
      clr = ($urandom_range(0, 60) == 0);
      g   = 10'($urandom);
      d   = bad ? (g ^ 10'($urandom)) : g;
      m   = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'h3FF;
      cycle(en, clr, d, g, m);
      for (int k = 0; k < 2; k++) begin
        n_chk++;
        if (obs_vec(k) !== exp_vec(k)) begin
          n_fail++; $display("FAIL random c=%0d k=%0d got=%h exp=%h", c, k, obs_vec(k), exp_vec(k));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_first();
    test_mask_en();
    test_bursts();
    test_saturate();
    test_reset_mid_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
